// File: rtl/sdram_model_pkg.sv
// Shared types for the block-RAM SDRAM channel responder.
package sdram_model_pkg;

  localparam int unsigned SDRAM_ADDR_W = 27;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef enum logic {CH1, CH2} ch_id_t;

  typedef struct packed {
    logic [SDRAM_ADDR_W-1:0] addr;
    logic [7:0]              din;
    logic                    rnw;
  } req_t;

endpackage

// File: rtl/sdram_bram_model_if.sv
// One SDRAM request channel: addr/din/rnw/req from the requester,
// ready/done/dout back from the responder.
interface sdram_bram_model_if;
  import sdram_model_pkg::*;

  logic [SDRAM_ADDR_W-1:0] addr;
  logic [7:0]              din;
  logic                    rnw;
  logic                    req;
  logic                    ready;
  logic                    done;
  logic [7:0]              dout;

  modport master (output addr, din, rnw, req, input ready, done, dout);
  modport slave  (input addr, din, rnw, req, output ready, done, dout);

endinterface

// File: rtl/sdram_model_port.sv
// Per-channel request capture: latches the request on a req/ready
// handshake, holds the pending flag and generates ready.
//   bus      - channel interface (slave side)
//   complete - one-cycle completion from the arbiter; drives done and
//              frees the channel in the same cycle
//   dout     - read data register from the top, passed to the channel
//   req      - latched request, address already reduced modulo 2^ADDR_W
//   pending  - request outstanding
module sdram_model_port
  import sdram_model_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  sdram_bram_model_if.slave   bus,
  input  logic                complete,
  input  logic [7:0]          dout,
  output req_t                req,
  output logic                pending
);

  localparam logic [SDRAM_ADDR_W-1:0] ADDR_MASK =
    SDRAM_ADDR_W'((64'd1 << ADDR_W) - 64'd1);

  req_t req_q, req_d;
  logic pending_q, pending_d;
  logic ready;
  logic accept;

  always_comb begin
    // ready is high in the completion cycle, so a held req is taken again
    ready     = !pending_q || complete;
    accept    = bus.req && ready;
    pending_d = pending_q;
    req_d     = req_q;
    if (complete) begin
      pending_d = 1'b0;
    end
    if (accept) begin
      pending_d  = 1'b1;
      req_d.addr = bus.addr & ADDR_MASK;
      req_d.din  = bus.din;
      req_d.rnw  = bus.rnw;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= 1'b0;
      req_q     <= '0;
    end else begin
      pending_q <= pending_d;
      req_q     <= req_d;
    end
  end

  assign bus.ready = ready;
  assign bus.done  = complete;
  assign bus.dout  = dout;
  assign req       = req_q;
  assign pending   = pending_q;

endmodule

// File: rtl/sdram_bram_model.sv
// Block-RAM responder for the SDRAM channel protocol. Two requesters,
// round-robin arbitration, fixed LATENCY cycles from grant to done.
//   clk, reset - clock, asynchronous active-high reset
//   ch1        - CPU/slot channel (read/write)
//   ch2        - flash loader channel
module sdram_bram_model
  import sdram_model_pkg::*;
#(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned LATENCY = 3
) (
  input  logic              clk,
  input  logic              reset,
  sdram_bram_model_if.slave ch1,
  sdram_bram_model_if.slave ch2
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  ch_id_t      gnt_q, gnt_d;
  ch_id_t      last_q, last_d;
  logic [7:0]  dout1_q, dout1_d;
  logic [7:0]  dout2_q, dout2_d;

  logic [7:0]  mem [DEPTH];

  req_t        req1, req2, acc_req;
  logic        pend1, pend2;
  logic        clear1, clear2;
  ch_id_t      pick, acc_ch;
  logic        access, mem_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [7:0]  rd_data;
  logic        unused_addr_bits;

  sdram_model_port #(.ADDR_W(ADDR_W)) u_port1 (
    .clk(clk), .reset(reset), .bus(ch1), .complete(clear1),
    .dout(dout1_q), .req(req1), .pending(pend1)
  );

  sdram_model_port #(.ADDR_W(ADDR_W)) u_port2 (
    .clk(clk), .reset(reset), .bus(ch2), .complete(clear2),
    .dout(dout2_q), .req(req2), .pending(pend2)
  );

  assign unused_addr_bits = ^{req1.addr, req2.addr};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    dout1_d = dout1_q;
    dout2_d = dout2_q;
    access  = 1'b0;
    mem_we  = 1'b0;
    clear1  = 1'b0;
    clear2  = 1'b0;

    if (pend1 && pend2) begin
      pick = (last_q == CH1) ? CH2 : CH1;
    end else begin
      pick = pend1 ? CH1 : CH2;
    end

    acc_ch   = (state_q == IDLE) ? pick : gnt_q;
    acc_req  = (acc_ch == CH1) ? req1 : req2;
    acc_addr = acc_req.addr[ADDR_W-1:0];
    rd_data  = mem[acc_addr];

    // The grant cycle counts toward LATENCY: BUSY spans LATENCY-1 cycles
    // and the access lands on the edge into DONE (from IDLE if LATENCY=1).
    unique case (state_q)
      IDLE: begin
        if (pend1 || pend2) begin
          gnt_d = pick;
          if (LATENCY == 1) begin
            access  = 1'b1;
            state_d = DONE;
          end else begin
            cnt_d   = 4'(LATENCY - 2);
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          access  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        if (gnt_q == CH1) begin
          clear1 = 1'b1;
        end else begin
          clear2 = 1'b1;
        end
        last_d  = gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (access) begin
      if (acc_req.rnw) begin
        if (acc_ch == CH1) begin
          dout1_d = rd_data;
        end else begin
          dout2_d = rd_data;
        end
      end else begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gnt_q   <= CH1;
      last_q  <= CH2;
      dout1_q <= '0;
      dout2_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      dout1_q <= dout1_d;
      dout2_q <= dout2_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[acc_addr] <= acc_req.din;
    end
  end

endmodule

// File: tb/tb_sdram_bram_model.sv
// Bench for sdram_bram_model: directed protocol/timing cases plus a
// randomized two-channel phase, checked by a completion-order memory model.
module tb_sdram_bram_model;

  localparam int unsigned AW  = 16;
  localparam int unsigned LAT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sdram_bram_model_if c1 ();
  sdram_bram_model_if c2 ();

  sdram_bram_model #(.ADDR_W(AW), .LATENCY(LAT)) dut (
    .clk(clk), .reset(rst), .ch1(c1), .ch2(c2)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [26:0] addr;
    logic [7:0]  din;
    logic        rnw;
    int          exp_cyc;
  } txn_t;

  txn_t q1[$];
  txn_t q2[$];
  int   order_q[$];
  logic [7:0] ref_mem [int];

  task automatic check(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int midx(logic [26:0] a);
    return int'(a) & ((1 << AW) - 1);
  endfunction

  // Effects are applied in completion order; one access in flight at a time.
  task automatic complete(int ch, logic [7:0] d);
    txn_t t;
    int   idx;
    if (((ch == 1) ? q1.size() : q2.size()) == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL unexpected_done_ch%0d: got done=1 expected done=0 (cycle %0d)", ch, cyc);
      return;
    end
    if (ch == 1) t = q1.pop_front();
    else         t = q2.pop_front();
    order_q.push_back(ch);
    if (t.exp_cyc >= 0) check($sformatf("ch%0d_done_cycle", ch), cyc, t.exp_cyc);
    idx = midx(t.addr);
    if (t.rnw) begin
      if (ref_mem.exists(idx)) check($sformatf("ch%0d_rdata@%0h", ch, idx), d, ref_mem[idx]);
    end else begin
      ref_mem[idx] = t.din;
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (c1.done) complete(1, c1.dout);
      if (c2.done) complete(2, c2.dout);
    end
  end

  task automatic drive(int ch, logic [26:0] a, logic [7:0] d, logic r, logic q);
    if (ch == 1) begin
      c1.addr = a; c1.din = d; c1.rnw = r; c1.req = q;
    end else begin
      c2.addr = a; c2.din = d; c2.rnw = r; c2.req = q;
    end
  endtask

  // lat > 0: expected done cycle = acceptance cycle + lat; lat < 0: unchecked.
  task automatic issue(int ch, logic [26:0] a, logic [7:0] d, logic r, int lat);
    txn_t t;
    int   n;
    bit   ok;
    n  = 0;
    ok = 1'b0;
    @(posedge clk); #1;
    drive(ch, a, d, r, 1'b1);
    while (n < 200) begin
      @(negedge clk);
      if ((ch == 1) ? c1.ready : c2.ready) begin
        ok = 1'b1;
        break;
      end
      n++;
    end
    if (!ok) begin
      n_vec++;
      n_bad++;
      $display("FAIL ready_timeout_ch%0d: got ready=0 expected ready=1 within 200 cycles", ch);
    end else begin
      t.addr    = a;
      t.din     = d;
      t.rnw     = r;
      t.exp_cyc = (lat > 0) ? cyc + lat : -1;
      if (ch == 1) q1.push_back(t);
      else         q2.push_back(t);
    end
    @(posedge clk); #1;
    drive(ch, a, d, r, 1'b0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q1.size() != 0 || q2.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      n_vec++;
      n_bad++;
      $display("FAIL idle_timeout: got %0d/%0d outstanding expected 0/0", q1.size(), q2.size());
      q1.delete();
      q2.delete();
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    drive(1, '0, '0, 1'b0, 1'b0);
    drive(2, '0, '0, 1'b0, 1'b0);
    q1.delete();
    q2.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  int pool [8] = '{'h1234, 'h0010, 'h0040, 'h0000, 'h0020, 'h0300, 'hBEEF, 'hFFFF};

  initial begin
    int t0;
    drive(1, '0, '0, 1'b0, 1'b0);
    drive(2, '0, '0, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    @(negedge clk);
    check("rst_ch1_ready", c1.ready, 1);
    check("rst_ch2_ready", c2.ready, 1);
    check("rst_ch1_done",  c1.done,  0);
    check("rst_ch2_done",  c2.done,  0);
    check("rst_ch1_dout",  c1.dout,  0);
    check("rst_ch2_dout",  c2.dout,  0);

    // uncontended ch2 write, cycle-exact
    @(posedge clk); #1;
    t0 = cyc;
    drive(2, 27'h0001234, 8'h5A, 1'b0, 1'b1);
    q2.push_back('{27'h0001234, 8'h5A, 1'b0, t0 + LAT + 1});
    @(negedge clk);
    check("t1_ch2_ready_c0", c2.ready, 1);
    @(posedge clk); #1;
    drive(2, 27'h0001234, 8'h5A, 1'b0, 1'b0);
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge clk);
      check($sformatf("t1_ch2_ready_c%0d", k), c2.ready, (k == LAT + 1) ? 1 : 0);
      check($sformatf("t1_ch2_done_c%0d",  k), c2.done,  (k == LAT + 1) ? 1 : 0);
      if (k <= LAT) @(posedge clk);
    end
    issue(1, 27'h0001234, 8'h00, 1'b1, LAT + 1);
    wait_idle();
    check("t1_ch1_dout", c1.dout, 8'h5A);

    // simultaneous requests after reset: ch1 wins the tie
    issue(1, 27'h10, 8'h11, 1'b0, LAT + 1);
    wait_idle();
    do_reset();
    @(negedge clk);
    check("t2_rst_ch1_dout", c1.dout, 0);
    fork
      issue(1, 27'h10, 8'h00, 1'b1, LAT + 1);
      issue(2, 27'h10, 8'h77, 1'b0, 2 * LAT + 2);
    join
    wait_idle();
    issue(1, 27'h10, 8'h00, 1'b1, LAT + 1);
    wait_idle();
    check("t2_ch1_dout_after", c1.dout, 8'h77);

    // round robin: pending ch2 served before ch1's second request
    order_q.delete();
    fork
      begin
        issue(1, 27'h300, 8'hA1, 1'b0, -1);
        issue(1, 27'h301, 8'hA2, 1'b0, -1);
      end
      begin
        @(posedge clk);
        issue(2, 27'h302, 8'hB1, 1'b0, -1);
      end
    join
    wait_idle();
    check("t3_order_len", order_q.size(), 3);
    if (order_q.size() == 3) begin
      check("t3_order_0", order_q[0], 1);
      check("t3_order_1", order_q[1], 2);
      check("t3_order_2", order_q[2], 1);
    end

    // req while not ready is ignored
    issue(1, 27'h40, 8'h33, 1'b0, LAT + 1);
    drive(1, 27'h40, 8'hAB, 1'b0, 1'b1);
    @(negedge clk);
    check("t4_ch1_ready_busy", c1.ready, 0);
    @(posedge clk); #1;
    drive(1, 27'h40, 8'hAB, 1'b0, 1'b0);
    wait_idle();
    repeat (8) @(negedge clk);
    issue(1, 27'h40, 8'h00, 1'b1, LAT + 1);
    wait_idle();
    check("t4_ch1_dout", c1.dout, 8'h33);

    // address wrap modulo 2^AW
    issue(1, 27'h0010000, 8'hC3, 1'b0, LAT + 1);
    issue(1, 27'h0000000, 8'h00, 1'b1, LAT + 1);
    wait_idle();
    check("t5_wrap_dout", c1.dout, 8'hC3);

    // reset before the access cycle cancels the write
    issue(2, 27'h20, 8'h00, 1'b0, LAT + 1);
    wait_idle();
    issue(1, 27'h20, 8'hEE, 1'b0, -1);
    @(posedge clk); #1;
    rst = 1'b1;
    q1.delete();
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (LAT + 4) @(negedge clk);
    check("t6_ch1_ready", c1.ready, 1);
    check("t6_ch2_ready", c2.ready, 1);
    issue(1, 27'h20, 8'h00, 1'b1, LAT + 1);
    wait_idle();
    check("t6_mem20", c1.dout, 8'h00);

    // randomized traffic on both channels
    fork
      for (int i = 0; i < 40; i++) begin
        logic [26:0] a;
        a = {11'($urandom), 16'(pool[$urandom_range(0, 7)])};
        repeat ($urandom_range(0, 2)) @(posedge clk);
        issue(1, a, 8'($urandom), 1'($urandom), -1);
      end
      for (int j = 0; j < 20; j++) begin
        logic [26:0] a;
        a = {11'($urandom), 16'(pool[$urandom_range(0, 7)])};
        repeat ($urandom_range(0, 3)) @(posedge clk);
        issue(2, a, 8'($urandom), ($urandom_range(0, 7) == 0), -1);
      end
    join
    wait_idle();
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
